// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment receiver: segment and nibble
// types, the active-low glyph table, FSM state encoding and an anode helper.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;     // {A,B,C,D,E,F,G}, active-low
    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } rx_state_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low glyphs for hex digits 0..F, indexed by the nibble they encode.
    localparam seg_t GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Index of the lowest active (low) anode; only meaningful when exactly one is low.
    function automatic logic [2:0] low_anode_idx(input logic [7:0] an);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (!an[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sevenseg_rx_if.sv
// Read/status bus of the seven-segment receiver. The receiver is the slave:
// it takes the read index and returns stored data, valid flags and event pulses.
interface sevenseg_rx_if;
    import sevenseg_pkg::*;

    logic [2:0] rd_sel;
    nibble_t    rd_num;
    logic       rd_valid;
    logic [7:0] digit_valid;
    logic       new_digit;
    logic [2:0] new_idx;
    logic       err_anode;
    logic       err_pattern;

    modport master (
        output rd_sel,
        input  rd_num, rd_valid, digit_valid, new_digit, new_idx, err_anode, err_pattern
    );

    modport slave (
        input  rd_sel,
        output rd_num, rd_valid, digit_valid, new_digit, new_idx, err_anode, err_pattern
    );

endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational glyph decoder: maps an active-low segment pattern back to the
// nibble it displays and flags whether the pattern is a legal hex glyph.
module seg_pattern_decode
    import sevenseg_pkg::*;
(
    input  seg_t    seg_i,
    output nibble_t num_o,
    output logic    legal_o
);

    // Search the glyph table; unmatched patterns (e.g. blank) stay illegal.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        num_o   = '0;
        legal_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == GLYPH[i]) begin
                num_o   = nibble_t'(i);
                legal_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sevenseg_rx.sv
// Seven-segment display receiver: samples the multiplexed anode/segment lines,
// waits for a one-hot digit to stay stable, decodes its glyph and stores the
// nibble in an 8-entry digit file with per-digit valid flags.
// Build option: define SEG_SYNC_EN to put a 2-flop synchronizer ahead of the
// sample register for asynchronous display lines (adds 2 cycles of latency).
module sevenseg_rx
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic an0, an1, an2, an3, an4, an5, an6, an7,
    input  logic segA, segB, segC, segD, segE, segF, segG,
    sevenseg_rx_if.slave st
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [14:0] raw_w;
    logic [14:0] s_q;
    logic [14:0] held_q;
    rx_state_t   state_q;
    logic [CNT_W-1:0] cnt_q;
    nibble_t     file_q [8];
    logic [7:0]  valid_q;
    logic        new_digit_q;
    logic [2:0]  new_idx_q;
    logic        err_anode_q;
    logic        err_pattern_q;

    logic [3:0]  low_cnt_w;
    logic [2:0]  held_idx_w;
    nibble_t     dec_num_w;
    logic        dec_legal_w;

`ifdef SEG_SYNC_EN
    logic [14:0] sync1_q, sync2_q;

    // Two-flop synchronizer; resets to all-ones so no anode appears active.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {an7, an6, an5, an4, an3, an2, an1, an0,
                        segA, segB, segC, segD, segE, segF, segG};
            sync2_q <= sync1_q;
        end
    end

    assign raw_w = sync2_q;
`else
    assign raw_w = {an7, an6, an5, an4, an3, an2, an1, an0,
                    segA, segB, segC, segD, segE, segF, segG};
`endif

    // Sample register: every stability decision is made on this copy only.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) s_q <= '0;
        else       s_q <= raw_w;
    end

    assign low_cnt_w  = 4'($countones(~s_q[14:7]));
    assign held_idx_w = low_anode_idx(held_q[14:7]);

    seg_pattern_decode u_decode (
        .seg_i   (held_q[6:0]),
        .num_o   (dec_num_w),
        .legal_o (dec_legal_w)
    );

    // Capture FSM, digit file and registered event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            held_q        <= '0;
            cnt_q         <= '0;
            valid_q       <= '0;
            new_digit_q   <= 1'b0;
            new_idx_q     <= '0;
            err_anode_q   <= 1'b0;
            err_pattern_q <= 1'b0;
            // NOTE: the digit file is cleared on reset because rd_num must read 0 afterwards.
            for (int i = 0; i < 8; i++) file_q[i] <= '0;
        end else begin
            new_digit_q   <= 1'b0;
            err_anode_q   <= 1'b0;
            err_pattern_q <= 1'b0;
            if (s_q != held_q) begin
                // Any change restarts qualification; this also kills a capture due this edge.
                held_q <= s_q;
                if (low_cnt_w == 4'd1) begin
                    state_q <= COUNT;
                    cnt_q   <= CNT_W'(1);
                end else begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    if (low_cnt_w > 4'd1) err_anode_q <= 1'b1;
                end
            end else if (state_q == COUNT) begin
                if (cnt_q == CNT_MAX) begin
                    state_q <= DONE;
                    if (dec_legal_w) begin
                        file_q[held_idx_w]  <= dec_num_w;
                        valid_q[held_idx_w] <= 1'b1;
                        new_digit_q         <= 1'b1;
                        new_idx_q           <= held_idx_w;
                    end else begin
                        err_pattern_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign st.rd_num      = file_q[st.rd_sel];
    assign st.rd_valid    = valid_q[st.rd_sel];
    assign st.digit_valid = valid_q;
    assign st.new_digit   = new_digit_q;
    assign st.new_idx     = new_idx_q;
    assign st.err_anode   = err_anode_q;
    assign st.err_pattern = err_pattern_q;

endmodule

// File: tb/tb_sevenseg_rx.sv
// Directed bench for sevenseg_rx: table of display patterns with expected
// event counts and timing, plus hand sequences for scan and reset corners.
module tb_sevenseg_rx;
    import sevenseg_pkg::*;

`ifdef SEG_SYNC_EN
    localparam int LAT = 8;   // steps from first drive to capture pulse
`else
    localparam int LAT = 6;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] an;
    seg_t       seg;

    always #5 clk = ~clk;

    sevenseg_rx_if bus();

    sevenseg_rx #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .an0   (an[0]), .an1 (an[1]), .an2 (an[2]), .an3 (an[3]),
        .an4   (an[4]), .an5 (an[5]), .an6 (an[6]), .an7 (an[7]),
        .segA  (seg[6]), .segB (seg[5]), .segC (seg[4]), .segD (seg[3]),
        .segE  (seg[2]), .segF (seg[1]), .segG (seg[0]),
        .st    (bus)
    );

    typedef struct {
        logic [7:0] an;
        seg_t       seg;
        int         cycles;
        int         exp_nd;
        int         exp_idx;
        int         exp_num;
        int         exp_ea;
        int         exp_ep;
        int         exp_first;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles with the current inputs, counting pulses and the step of the first one.
    task automatic run(input int n, output int nd, output int idx, output int ea,
                       output int ep, output int first);
        nd = 0; idx = -1; ea = 0; ep = 0; first = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (bus.new_digit) begin
                nd++;
                idx = int'(bus.new_idx);
                if (first == 0) first = k;
            end
            if (bus.err_anode) begin
                ea++;
                if (first == 0) first = k;
            end
            if (bus.err_pattern) begin
                ep++;
                if (first == 0) first = k;
            end
        end
    endtask

    vec_t vecs [9];
    seg_t tb_glyph [8];
    seg_t glyph_f;

    initial begin
        int nd, idx, ea, ep, first, nd_sum;

        tb_glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                     7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
        glyph_f  = 7'b0111000;

        //          an     seg         cyc nd idx num ea ep first
        vecs[0] = '{8'hFF, 7'b1111111,  3, 0, 0, 0,   0, 0, 0};
        vecs[1] = '{8'hFB, 7'b0010010, 10, 1, 2, 2,   0, 0, LAT};
        vecs[2] = '{8'hDF, 7'b1000010,  3, 0, 0, 0,   0, 0, 0};
        vecs[3] = '{8'hBF, 7'b1000010,  8, 1, 6, 13,  0, 0, LAT};
        vecs[4] = '{8'h7E, 7'b0000000,  6, 0, 0, 0,   1, 0, LAT - 4};
        vecs[5] = '{8'hEF, 7'b1111111,  8, 0, 0, 0,   0, 1, LAT};
        vecs[6] = '{8'hFD, 7'b1001111,  4, 0, 0, 0,   0, 0, 0};
        vecs[7] = '{8'hFB, 7'b0001111,  8, 1, 2, 7,   0, 0, LAT};
        vecs[8] = '{8'hFF, 7'b1111111,  4, 0, 0, 0,   0, 0, 0};

        // Reset for two cycles with the display dark.
        reset = 1'b1;
        an    = 8'hFF;
        seg   = 7'b1111111;
        bus.rd_sel = 3'd0;
        step();
        step();
        check("rst_valid", 32'(bus.digit_valid), 32'h00);
        check("rst_new_digit", 32'(bus.new_digit), 32'd0);
        check("rst_err_anode", 32'(bus.err_anode), 32'd0);
        check("rst_err_pattern", 32'(bus.err_pattern), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel = 3'(i);
            #1;
            check($sformatf("rst_rd_num%0d", i), 32'(bus.rd_num), 32'd0);
        end
        reset = 1'b0;

        // Table-driven patterns.
        for (int v = 0; v < 9; v++) begin
            an  = vecs[v].an;
            seg = vecs[v].seg;
            run(vecs[v].cycles, nd, idx, ea, ep, first);
            check($sformatf("v%0d_new_digit_cnt", v), 32'(nd), 32'(vecs[v].exp_nd));
            check($sformatf("v%0d_err_anode_cnt", v), 32'(ea), 32'(vecs[v].exp_ea));
            check($sformatf("v%0d_err_pattern_cnt", v), 32'(ep), 32'(vecs[v].exp_ep));
            if (vecs[v].exp_first != 0)
                check($sformatf("v%0d_pulse_step", v), 32'(first), 32'(vecs[v].exp_first));
            if (vecs[v].exp_nd != 0) begin
                check($sformatf("v%0d_new_idx", v), 32'(idx), 32'(vecs[v].exp_idx));
                bus.rd_sel = 3'(vecs[v].exp_idx);
                #1;
                check($sformatf("v%0d_rd_num", v), 32'(bus.rd_num), 32'(vecs[v].exp_num));
                check($sformatf("v%0d_rd_valid", v), 32'(bus.rd_valid), 32'd1);
            end
        end
        check("tbl_digit_valid", 32'(bus.digit_valid), 32'h44);
        bus.rd_sel = 3'd5;
        #1;
        check("glitch_digit5_invalid", 32'(bus.rd_valid), 32'd0);
        bus.rd_sel = 3'd4;
        #1;
        check("blank_digit4_invalid", 32'(bus.rd_valid), 32'd0);

        // Full scan: digits 0..7 show 0..7, then every digit shows F.
        nd_sum = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int d = 0; d < 8; d++) begin
                an  = ~(8'h01 << d);
                seg = (pass == 0) ? tb_glyph[d] : glyph_f;
                run(6, nd, idx, ea, ep, first);
                nd_sum += nd;
                if (ea + ep != 0) check($sformatf("scan_err_p%0d_d%0d", pass, d), 32'(ea + ep), 32'd0);
            end
        end
        an  = 8'hFF;
        seg = 7'b1111111;
        run(4, nd, idx, ea, ep, first);
        nd_sum += nd;
        check("scan_new_digit_total", 32'(nd_sum), 32'd16);
        check("scan_digit_valid", 32'(bus.digit_valid), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel = 3'(i);
            #1;
            check($sformatf("scan_rd_num%0d", i), 32'(bus.rd_num), 32'hF);
        end

        // Reset mid-count: digit 3 held two cycles, then reset clears everything.
        an  = 8'hF7;
        seg = 7'b0000110;
        step();
        step();
        reset = 1'b1;
        an    = 8'hFF;
        seg   = 7'b1111111;
        step();
        check("midrst_digit_valid", 32'(bus.digit_valid), 32'h00);
        check("midrst_new_digit", 32'(bus.new_digit), 32'd0);
        bus.rd_sel = 3'd7;
        #1;
        check("midrst_rd_num7", 32'(bus.rd_num), 32'd0);
        step();
        reset = 1'b0;
        run(8, nd, idx, ea, ep, first);
        check("midrst_no_capture", 32'(nd + ea + ep), 32'd0);
        check("midrst_valid_after", 32'(bus.digit_valid), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
